// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin write-back arbiter, registered regfile write port and RAW scoreboard.
// Optional WB_BYPASS_EN adds same-cycle forwarding of the committing write to the decode read ports.
module regfile_wb_arbiter #(
  parameter int NREQ = 2,
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*XLEN-1:0] req_data,
  input  logic                 alloc_valid,
  input  logic [AW-1:0]        alloc_addr,
  input  logic [AW-1:0]        rd_addr1,
  input  logic [AW-1:0]        rd_addr2,
  output logic                 rd_busy1,
  output logic                 rd_busy2,
`ifdef WB_BYPASS_EN
  output logic                 byp_hit1,
  output logic                 byp_hit2,
  output logic [XLEN-1:0]      byp_data1,
  output logic [XLEN-1:0]      byp_data2,
`endif
  input  logic                 flush,
  output logic                 regwrite,
  output logic [AW-1:0]        writereg,
  output logic [XLEN-1:0]      writedata
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NR = 1 << AW;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d, gidx;
  logic [NR-1:0]   pending_q, pending_d;
  logic            regwrite_q;
  logic [AW-1:0]   writereg_q, g_addr;
  logic [XLEN-1:0] writedata_q, g_data;
  logic            found, xfer;
  always_comb begin
    gidx  = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
        found = 1'b1;
        gidx  = PW'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end
  // reset level gates the grant so nothing is handshaken while rst is held low
  assign xfer      = found && rst && !flush;
  assign req_ready = xfer ? (NREQ'(1) << gidx) : '0;
  assign g_addr    = req_addr[int'(gidx)*AW +: AW];
  assign g_data    = req_data[int'(gidx)*XLEN +: XLEN];
  assign rr_ptr_d  = xfer ? ((int'(gidx) == NREQ-1) ? '0 : gidx + 1'b1) : rr_ptr_q;
  always_comb begin
    pending_d = pending_q;
    if (regwrite_q) pending_d[writereg_q] = 1'b0;
    if (alloc_valid && alloc_addr != '0) pending_d[alloc_addr] = 1'b1;
    if (flush) pending_d = '0;
    pending_d[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q    <= '0;
      pending_q   <= '0;
      regwrite_q  <= 1'b0;
      writereg_q  <= '0;
      writedata_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      pending_q  <= pending_d;
      regwrite_q <= xfer && g_addr != '0;
      if (xfer) begin
        writereg_q  <= g_addr;
        writedata_q <= g_data;
      end
    end
  end
  assign regwrite  = regwrite_q;
  assign writereg  = writereg_q;
  assign writedata = writedata_q;
`ifdef WB_BYPASS_EN
  assign byp_hit1  = regwrite_q && rd_addr1 == writereg_q && rd_addr1 != '0;
  assign byp_hit2  = regwrite_q && rd_addr2 == writereg_q && rd_addr2 != '0;
  assign byp_data1 = byp_hit1 ? writedata_q : '0;
  assign byp_data2 = byp_hit2 ? writedata_q : '0;
  assign rd_busy1  = pending_q[rd_addr1] && !byp_hit1;
  assign rd_busy2  = pending_q[rd_addr2] && !byp_hit2;
`else
  assign rd_busy1  = pending_q[rd_addr1];
  assign rd_busy2  = pending_q[rd_addr2];
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: randomized and directed checks against a behavioural write-back/scoreboard model.
module tb_regfile_wb_arbiter;
  localparam int NREQ = 2;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid, req_ready;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*XLEN-1:0] req_data;
  logic                 alloc_valid;
  logic [AW-1:0]        alloc_addr, rd_addr1, rd_addr2;
  logic                 rd_busy1, rd_busy2, flush, regwrite;
  logic [AW-1:0]        writereg;
  logic [XLEN-1:0]      writedata;
`ifdef WB_BYPASS_EN
  logic                 byp_hit1, byp_hit2;
  logic [XLEN-1:0]      byp_data1, byp_data2;
`endif
  always #5 clk = ~clk;
  regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .alloc_valid(alloc_valid),
    .alloc_addr(alloc_addr), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
`ifdef WB_BYPASS_EN
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2), .byp_data1(byp_data1), .byp_data2(byp_data2),
`endif
    .flush(flush), .regwrite(regwrite), .writereg(writereg), .writedata(writedata)
  );
  int errs = 0, checks = 0;
  int m_ptr;
  bit m_pend[32];
  bit m_we;
  int m_wr;
  logic [XLEN-1:0] m_wd;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int exp_grant();
    if (!rst || flush) return -1;
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction
  function automatic bit exp_busy(input int ra);
    bit hit;
    hit = m_we && ra == m_wr && ra != 0;
`ifdef WB_BYPASS_EN
    return m_pend[ra] && !hit;
`else
    return m_pend[ra];
`endif
  endfunction
  task automatic model_reset();
    m_ptr = 0; m_we = 0; m_wr = 0; m_wd = '0;
    for (int i = 0; i < 32; i++) m_pend[i] = 0;
  endtask
  task automatic rand_inputs();
    req_valid   = NREQ'($urandom);
    req_addr    = {NREQ{AW'($urandom)}} ^ NREQ*AW'($urandom);
    req_data    = {$urandom, $urandom};
    alloc_valid = 1'($urandom);
    alloc_addr  = AW'($urandom);
    rd_addr1    = AW'($urandom);
    rd_addr2    = AW'($urandom);
    flush       = 1'($urandom);
  endtask
  task automatic idle();
    req_valid = '0; alloc_valid = 0; flush = 0;
  endtask
  // Called just after a falling edge with inputs settled; returns the granted index (-1 if none).
  task automatic step(output int g);
    logic [NREQ-1:0] er;
    int ga;
    #1;
    g  = exp_grant();
    er = (g >= 0) ? NREQ'(1) << g : '0;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("rd_busy1", 64'(rd_busy1), 64'(exp_busy(int'(rd_addr1))));
    chk("rd_busy2", 64'(rd_busy2), 64'(exp_busy(int'(rd_addr2))));
`ifdef WB_BYPASS_EN
    chk("byp_hit2", 64'(byp_hit2), 64'(m_we && int'(rd_addr2) == m_wr && rd_addr2 != 0));
    chk("byp_data2", 64'(byp_data2), (m_we && int'(rd_addr2) == m_wr && rd_addr2 != 0) ? 64'(m_wd) : 64'd0);
`endif
    @(posedge clk);
    if (m_we) m_pend[m_wr] = 0;
    if (alloc_valid && alloc_addr != 0) m_pend[alloc_addr] = 1;
    if (flush) for (int i = 0; i < 32; i++) m_pend[i] = 0;
    m_we = 0;
    if (g >= 0) begin
      ga    = int'(req_addr[g*AW +: AW]);
      m_wr  = ga;
      m_wd  = req_data[g*XLEN +: XLEN];
      m_we  = ga != 0;
      m_ptr = (g + 1) % NREQ;
    end
    #1;
    chk("regwrite", 64'(regwrite), 64'(m_we));
    chk("writereg", 64'(writereg), 64'(m_wr));
    chk("writedata", 64'(writedata), 64'(m_wd));
    @(negedge clk);
  endtask
  task automatic hold_reset(input int n);
    for (int c = 0; c < n; c++) begin
      rand_inputs();
      #1;
      chk("rst_regwrite", 64'(regwrite), 64'd0);
      chk("rst_writereg", 64'(writereg), 64'd0);
      chk("rst_writedata", 64'(writedata), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_busy", 64'({rd_busy1, rd_busy2}), 64'd0);
      @(negedge clk);
    end
    model_reset();
    idle();
    rst = 1;
  endtask
  initial begin
    int g;
    rst = 0;
    rd_addr1 = '0; rd_addr2 = '0; req_addr = '0; req_data = '0; alloc_addr = '0;
    idle();
    @(negedge clk);
    hold_reset(4);
    req_valid = 2'b11;
    req_addr  = {AW'(6), AW'(5)};
    req_data  = {32'h5555FFFF, 32'hAAAA0000};
    for (int k = 0; k < 4; k++) begin
      step(g);
      chk("rr_grant", 64'(g), 64'(k % 2));
      chk("rr_writereg", 64'(writereg), (k % 2) ? 64'd6 : 64'd5);
      chk("rr_regwrite", 64'(regwrite), 64'd1);
    end
    req_valid = 2'b01;
    req_addr  = {AW'(6), AW'(0)};
    req_data  = {32'h5555FFFF, 32'hDEADBEEF};
    step(g);
    chk("x0_grant", 64'(g), 64'd0);
    chk("x0_regwrite", 64'(regwrite), 64'd0);
    req_valid = 2'b11;
    step(g);
    chk("x0_ptr_adv", 64'(g), 64'd1);
    idle();
    alloc_valid = 1; alloc_addr = 7; rd_addr1 = 7;
    step(g);
    alloc_valid = 0;
    #1 chk("sb_set", 64'(rd_busy1), 64'd1);
    req_valid = 2'b01; req_addr = {AW'(0), AW'(7)}; req_data = {32'h0, 32'h12345678};
    step(g);
    idle();
    chk("sb_commit", 64'({regwrite, writereg}), {58'd0, 1'b1, 5'd7});
    step(g);
    chk("sb_clear", 64'(rd_busy1), 64'd0);
    alloc_valid = 1;
    step(g);
    req_valid = 2'b01; alloc_valid = 0;
    step(g);
    alloc_valid = 1; req_valid = 0;
    step(g);
    alloc_valid = 0;
    #1 chk("sb_set_wins", 64'(rd_busy1), 64'd1);
    alloc_valid = 1; alloc_addr = 3;
    step(g);
    alloc_addr = 9; req_valid = 2'b01; req_addr = {AW'(12), AW'(9)};
    step(g);
    alloc_valid = 0; flush = 1; req_valid = 2'b10; rd_addr1 = 3; rd_addr2 = 9;
    #1 chk("flush_prewrite", 64'(regwrite), 64'd1);
    step(g);
    flush = 0; req_valid = 0;
    chk("flush_regwrite", 64'(regwrite), 64'd0);
    #1 chk("flush_pending", 64'({rd_busy1, rd_busy2}), 64'd0);
    alloc_valid = 1; alloc_addr = 4;
    step(g);
    alloc_valid = 0; req_valid = 2'b10; req_addr = {AW'(4), AW'(0)}; req_data = {32'hCAFEF00D, 32'h0};
    step(g);
    idle();
    rd_addr2 = 4;
`ifdef WB_BYPASS_EN
    #1;
    chk("byp_hit", 64'(byp_hit2), 64'd1);
    chk("byp_data", 64'(byp_data2), 64'hCAFEF00D);
    chk("byp_busy", 64'(rd_busy2), 64'd0);
`endif
    #2 rst = 0;
    #1 chk("async_regwrite", 64'(regwrite), 64'd0);
    chk("async_writereg", 64'(writereg), 64'd0);
    @(negedge clk);
    hold_reset(3);
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && $urandom_range(2) == 0) begin
          req_valid[i] = 1;
          req_addr[i*AW +: AW] = AW'($urandom_range(7));
          req_data[i*XLEN +: XLEN] = $urandom;
        end
      alloc_valid = 1'($urandom);
      alloc_addr  = AW'($urandom_range(7));
      rd_addr1    = AW'($urandom_range(7));
      rd_addr2    = AW'($urandom_range(7));
      flush       = $urandom_range(15) == 0;
      step(g);
      if (g >= 0) req_valid[g] = 0;
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-back arbiter and scoreboard in front of the 32x32 register file's single write port.
- Shares that write port between NREQ write-back requesters (e.g. ALU path, load/multicycle unit) using round-robin, with a valid/ready handshake.
- Drives the register file's regwrite/writereg/writedata through one registered stage.
- Tracks in-flight destination registers so decode can stall on RAW hazards.

Parameters:
- NREQ, 2, number of write-back requesters (2..4).
- XLEN, 32, data width.
- AW, 5, register address width (32 registers).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserts immediately when low; released synchronously by the user).
- req_valid  in  NREQ  per-requester write request.
- req_ready  out  NREQ  per-requester grant; a transfer occurs when valid and ready are both high.
- req_addr  in  NREQ*AW  packed destination register; requester i occupies bits [i*AW +: AW].
- req_data  in  NREQ*XLEN  packed write data; requester i occupies bits [i*XLEN +: XLEN].
- alloc_valid  in  1  decode issued an instruction with a destination register.
- alloc_addr  in  AW  destination register to mark pending.
- rd_addr1, rd_addr2  in  AW each  decode source registers to query.
- rd_busy1, rd_busy2  out  1 each  source register has a pending write.
- flush  in  1  pipeline flush.
- regwrite  out  1  register file write enable.
- writereg  out  AW  register file write address.
- writedata  out  XLEN  register file write data.

Behaviour:
- Reset (rst low): regwrite=0, writereg=0, writedata=0, pending[31:0]=0, rr_ptr=0. req_ready=0 while reset is held.
- Arbitration (combinational):
  - Among asserted req_valid, search from index rr_ptr upward, wrapping modulo NREQ. The first valid index is granted.
  - At most one req_ready bit is high; that bit is high only if the corresponding req_valid is high.
  - Requesters must not make valid depend on ready. Once valid is asserted, addr and data must be held stable until the transfer.
- Pointer: after a transfer from index g, rr_ptr <= (g+1) mod NREQ. With no transfer, rr_ptr holds.
- Output stage (latency 1): on a transfer, the next clock edge loads writereg=addr and writedata=data.
  - regwrite=1 if addr != 0. For addr == 0, regwrite=0: the transfer is accepted and discarded.
  - With no transfer, regwrite=0 next cycle; writereg and writedata hold their values.
  - There is no backpressure from the register file, so one transfer per cycle is sustained.
- Scoreboard:
  - alloc_valid with alloc_addr != 0 sets pending[alloc_addr] at the clock edge.
  - A cycle with regwrite=1 clears pending[writereg] at the clock edge.
  - If the same register is set and cleared in the same cycle, the set wins.
  - pending[0] is always 0.
  - rd_busyN = pending[rd_addrN] (combinational). Address 0 always returns 0.
- Flush:
  - Forces req_ready=0 during the flush cycle.
  - Clears all pending bits. A same-cycle alloc is ignored.
  - Forces regwrite=0 on the next cycle.
  - A write already on the output (regwrite=1 during the flush cycle) still commits to the register file.
  - rr_ptr holds.
- Reset mid-operation: all state clears immediately. Any in-flight write is dropped.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - Adds outputs byp_hit1, byp_hit2 (1 each) and byp_data1, byp_data2 (XLEN each).
  - byp_hitN=1 when regwrite=1, rd_addrN == writereg and rd_addrN != 0; byp_dataN=writedata in that case.
  - When byp_hitN=1, rd_busyN is forced to 0 (the value is forwarded in the same cycle as the write).
  - byp_dataN is 0 when byp_hitN=0.
- Undefined: these ports are absent, and rd_busyN stays high until the cycle after the write commits.

Test Plan:
- Reset: hold rst=0 with random inputs -> regwrite=0, writereg=0, writedata=0, rd_busy1=rd_busy2=0, req_ready=0. Release -> first grant goes to requester 0.
- Round-robin: both requesters valid for 4 cycles (req0 addr=5 data=0xAAAA0000, req1 addr=6 data=0x5555FFFF) -> grants 0,1,0,1. regwrite=1 each cycle from cycle 1 on, writereg alternating 5,6,5,6.
- x0 discard: req0 valid with addr=0 and data=0xDEADBEEF -> req_ready[0]=1, regwrite=0 next cycle, rr_ptr advances to 1.
- Scoreboard: alloc reg 7, then rd_addr1=7 -> rd_busy1=1. Write to reg 7 commits (regwrite=1, writereg=7) -> rd_busy1=0 the cycle after. Repeat with alloc 7 in the commit cycle -> rd_busy1 stays 1.
- Flush: pending={3,9}, req1 valid, flush=1 -> req_ready=0, pending cleared, regwrite=0 next cycle. A pre-existing regwrite=1 output still commits during the flush cycle.
- Async reset mid-write: drive rst low between clock edges while regwrite=1 -> regwrite=0 immediately, before the next edge. With WB_BYPASS_EN: writereg=4, regwrite=1, rd_addr2=4 -> byp_hit2=1, byp_data2=writedata, rd_busy2=0.
